// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and default 800x600@72 timing for the VGA raster controller
package vga_pkg;

   typedef enum logic [1:0] {
      AX_SYNC   = 2'd0,
      AX_BACK   = 2'd1,
      AX_ACTIVE = 2'd2,
      AX_FRONT  = 2'd3
   } axis_state_t;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 56;
   localparam int H_SYNC_DEF   = 120;
   localparam int H_BP_DEF     = 64;
   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 37;
   localparam int V_SYNC_DEF   = 6;
   localparam int V_BP_DEF     = 23;

   function automatic axis_state_t axis_next(input axis_state_t s);
      case (s)
         AX_SYNC:   axis_next = AX_BACK;
         AX_BACK:   axis_next = AX_ACTIVE;
         AX_ACTIVE: axis_next = AX_FRONT;
         default:   axis_next = AX_SYNC;
      endcase
   endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// rtl/vga_axis_fsm.sv - one timing axis: SYNC/BACK/ACTIVE/FRONT sequencer with total and in-state counters
// Exposes the values the registers take at the coming edge so the top can register outputs that match them.
module vga_axis_fsm
   import vga_pkg::*;
#(
   parameter int CNT_W   = 11,
   parameter int SYNC_W  = 120,
   parameter int BACK_W  = 64,
   parameter int ACT_W   = 800,
   parameter int FRONT_W = 56
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   output logic [CNT_W-1:0]  cnt_nxt,
   output axis_state_t       state_nxt,
   output logic              wrap
);

   localparam int               TOT  = SYNC_W + BACK_W + ACT_W + FRONT_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOT - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] seg;
   logic [CNT_W-1:0] seg_nxt;
   logic [CNT_W-1:0] seg_last;
   axis_state_t      state;

   always_comb begin
      case (state)
         AX_SYNC:   seg_last = CNT_W'(SYNC_W - 1);
         AX_BACK:   seg_last = CNT_W'(BACK_W - 1);
         AX_ACTIVE: seg_last = CNT_W'(ACT_W - 1);
         default:   seg_last = CNT_W'(FRONT_W - 1);
      endcase
   end

   always_comb begin
      cnt_nxt   = cnt;
      seg_nxt   = seg;
      state_nxt = state;
      wrap      = 1'b0;
      if (clr) begin
         cnt_nxt   = '0;
         seg_nxt   = '0;
         state_nxt = AX_SYNC;
      end else if (en) begin
         wrap    = (cnt == LAST);
         cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
         if (seg == seg_last) begin
            seg_nxt   = '0;
            state_nxt = axis_next(state);
         end else begin
            seg_nxt = seg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         seg   <= '0;
         state <= AX_SYNC;
      end else begin
         cnt   <= cnt_nxt;
         seg   <= seg_nxt;
         state <= state_nxt;
      end
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster scan controller: registered HS/VS/DE/coordinates plus line-fetch scheduling
// Fetch scheduler and UNDERRUN are built only when VGA_LINE_FETCH_EN is defined; otherwise they are tied to 0.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  logic            PIX_CLK,
   input  logic            RST_N,
   input  logic            EN,
   output logic            HS,
   output logic            VS,
   output logic            DE,
   output logic [X_W-1:0]  PIX_X,
   output logic [Y_W-1:0]  PIX_Y,
   output logic            FETCH_REQ,
   output logic [Y_W-1:0]  FETCH_ROW,
   input  logic            FETCH_ACK,
   output logic            UNDERRUN
);

   localparam logic [X_W-1:0] H_ACT_START = X_W'(H_SYNC + H_BP);
   localparam logic [Y_W-1:0] V_ACT_START = Y_W'(V_SYNC + V_BP);

   logic           running;
   logic           clr;
   logic           h_en;
   logic           v_en;
   logic           h_wrap;
   logic           v_wrap_unused;
   logic [X_W-1:0] hc_nxt;
   logic [Y_W-1:0] vc_nxt;
   axis_state_t    h_state_nxt;
   axis_state_t    v_state_nxt;
   logic           de_nxt;

   // The first enabled edge only loads outputs for (0,0); counting begins once running is set.
   assign clr  = ~EN;
   assign h_en = running;
   assign v_en = running & h_wrap;

   vga_axis_fsm #(
      .CNT_W(X_W), .SYNC_W(H_SYNC), .BACK_W(H_BP), .ACT_W(H_ACTIVE), .FRONT_W(H_FP)
   ) u_h_fsm (
      .clk(PIX_CLK), .rst_n(RST_N), .clr(clr), .en(h_en),
      .cnt_nxt(hc_nxt), .state_nxt(h_state_nxt), .wrap(h_wrap)
   );

   vga_axis_fsm #(
      .CNT_W(Y_W), .SYNC_W(V_SYNC), .BACK_W(V_BP), .ACT_W(V_ACTIVE), .FRONT_W(V_FP)
   ) u_v_fsm (
      .clk(PIX_CLK), .rst_n(RST_N), .clr(clr), .en(v_en),
      .cnt_nxt(vc_nxt), .state_nxt(v_state_nxt), .wrap(v_wrap_unused)
   );

   assign de_nxt = (h_state_nxt == AX_ACTIVE) && (v_state_nxt == AX_ACTIVE);

   always_ff @(posedge PIX_CLK or negedge RST_N) begin
      if (!RST_N) begin
         running <= 1'b0;
         HS      <= ~HS_POL;
         VS      <= ~VS_POL;
         DE      <= 1'b0;
         PIX_X   <= '0;
         PIX_Y   <= '0;
      end else if (!EN) begin
         running <= 1'b0;
         HS      <= ~HS_POL;
         VS      <= ~VS_POL;
         DE      <= 1'b0;
         PIX_X   <= '0;
         PIX_Y   <= '0;
      end else begin
         running <= 1'b1;
         HS      <= (h_state_nxt == AX_SYNC) ? HS_POL : ~HS_POL;
         VS      <= (v_state_nxt == AX_SYNC) ? VS_POL : ~VS_POL;
         DE      <= de_nxt;
         PIX_X   <= de_nxt ? hc_nxt - H_ACT_START : '0;
         PIX_Y   <= de_nxt ? vc_nxt - V_ACT_START : '0;
      end
   end

`ifdef VGA_LINE_FETCH_EN
   localparam logic [X_W-1:0] H_FRONT_START = X_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [Y_W-1:0] V_ACT_END     = Y_W'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [Y_W-1:0] V_LAST        = Y_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

   logic [Y_W-1:0] next_line;
   logic           next_active;
   logic           front_entry;
   logic           active_entry;

   assign next_line    = (vc_nxt == V_LAST) ? '0 : vc_nxt + Y_W'(1);
   assign next_active  = (next_line >= V_ACT_START) && (next_line <= V_ACT_END);
   assign front_entry  = running && (hc_nxt == H_FRONT_START);
   assign active_entry = running && (hc_nxt == H_ACT_START);

   // An ACK sampled on the same edge the target line goes active still wins over UNDERRUN.
   always_ff @(posedge PIX_CLK or negedge RST_N) begin
      if (!RST_N) begin
         FETCH_REQ <= 1'b0;
         FETCH_ROW <= '0;
         UNDERRUN  <= 1'b0;
      end else if (!EN) begin
         FETCH_REQ <= 1'b0;
         FETCH_ROW <= '0;
         UNDERRUN  <= 1'b0;
      end else begin
         UNDERRUN <= 1'b0;
         if (FETCH_REQ && FETCH_ACK) begin
            FETCH_REQ <= 1'b0;
         end else if (FETCH_REQ && active_entry) begin
            FETCH_REQ <= 1'b0;
            UNDERRUN  <= 1'b1;
         end else if (front_entry && next_active) begin
            FETCH_REQ <= 1'b1;
            FETCH_ROW <= next_line - V_ACT_START;
         end
      end
   end
`else
   logic unused_fetch_ack;

   assign unused_fetch_ack = FETCH_ACK;
   assign FETCH_REQ        = 1'b0;
   assign FETCH_ROW        = '0;
   assign UNDERRUN         = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - self-checking bench for vga_scan_ctrl on a shrunken raster
module tb_vga_scan_ctrl;

   localparam int H_SYNC = 6, H_BP = 5, H_ACT = 16, H_FP = 4;
   localparam int V_SYNC = 2, V_BP = 4, V_ACT = 10, V_FP = 3;
   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HA0 = H_SYNC + H_BP;
   localparam int HF0 = HA0 + H_ACT;
   localparam int VA0 = V_SYNC + V_BP;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int LAST_OK = H_TOT - HF0 + HA0 - 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        ack = 1'b0;
   logic        HS, VS, DE, FETCH_REQ, UNDERRUN;
   logic [10:0] PIX_X;
   logic [9:0]  PIX_Y, FETCH_ROW;

   int n_pass = 0, n_total = 0;
   bit chk_on = 1'b0;
   int ack_mode = 0;
   int ack_dly = 0;

   int m_hc = 0, m_vc = 0, m_row = 0;
   bit m_run = 1'b0, m_req = 1'b0, m_und = 1'b0;

   int c_hs, c_vs, c_de, c_req, c_und, c_req_bad, c_und_bad, first_de;
   int rows[$];

   vga_scan_ctrl #(
      .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b1), .VS_POL(1'b0)
   ) dut (
      .PIX_CLK(clk), .RST_N(rst_n), .EN(en),
      .HS(HS), .VS(VS), .DE(DE), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
      .FETCH_REQ(FETCH_REQ), .FETCH_ROW(FETCH_ROW), .FETCH_ACK(ack), .UNDERRUN(UNDERRUN)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
   endtask

   // Reference raster: plain position counters, fetch rules in terms of line/column numbers.
   always @(posedge clk or negedge rst_n) begin : model
      int nh, nv, nl;
      if (!rst_n || !en) begin
         m_run <= 1'b0; m_hc <= 0; m_vc <= 0;
         m_req <= 1'b0; m_und <= 1'b0; m_row <= 0;
      end else if (!m_run) begin
         m_run <= 1'b1;
         m_und <= 1'b0;
      end else begin
         nh = (m_hc + 1) % H_TOT;
         nv = (nh == 0) ? (m_vc + 1) % V_TOT : m_vc;
         nl = (nv + 1) % V_TOT;
         m_hc  <= nh;
         m_vc  <= nv;
         m_und <= 1'b0;
         if (m_req && ack) begin
            m_req <= 1'b0;
         end else if (m_req && nh == HA0) begin
            m_req <= 1'b0;
            m_und <= 1'b1;
         end else if (nh == HF0 && nl >= VA0 && nl < VA0 + V_ACT) begin
            m_req <= 1'b1;
            m_row <= nl - VA0;
         end
      end
   end

   initial begin : compare
      int e_hs, e_vs, e_de;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            e_hs = (m_run && m_hc < H_SYNC) ? 1 : 0;
            e_vs = (m_run && m_vc < V_SYNC) ? 0 : 1;
            e_de = (m_run && m_hc >= HA0 && m_hc < HF0 && m_vc >= VA0 && m_vc < VA0 + V_ACT) ? 1 : 0;
            chk("hs", int'(HS), e_hs);
            chk("vs", int'(VS), e_vs);
            chk("de", int'(DE), e_de);
            chk("pix_x", int'(PIX_X), e_de ? m_hc - HA0 : 0);
            chk("pix_y", int'(PIX_Y), e_de ? m_vc - VA0 : 0);
`ifdef VGA_LINE_FETCH_EN
            chk("fetch_req", int'(FETCH_REQ), int'(m_req));
            chk("underrun", int'(UNDERRUN), int'(m_und));
            if (m_req) chk("fetch_row", int'(FETCH_ROW), m_row);
`else
            chk("fetch_req_off", int'(FETCH_REQ), 0);
            chk("underrun_off", int'(UNDERRUN), 0);
            chk("fetch_row_off", int'(FETCH_ROW), 0);
`endif
         end
      end
   end

   // ACK driver: timed from the REQ rise so a late ACK can land after REQ has already dropped.
   initial begin : ack_drv
      int age;
      bit prev, act;
      age = 0; prev = 1'b0; act = 1'b0;
      forever begin
         @(negedge clk);
         if (FETCH_REQ && !prev) begin
            age = 0;
            act = 1'b1;
            if (ack_mode == 3) ack_dly = $urandom_range(0, LAST_OK + 2);
         end
         prev = FETCH_REQ;
         if (ack_mode == 0) ack = 1'b1;
         else ack = act && (ack_mode != 2) && (age == ack_dly);
         if (act) begin
            age++;
            if (age > LAST_OK + 4) act = 1'b0;
         end
      end
   end

   task automatic run_cnt(input int n);
      bit prev_r;
      c_hs = 0; c_vs = 0; c_de = 0; c_req = 0; c_und = 0;
      c_req_bad = 0; c_und_bad = 0; first_de = -1; prev_r = 1'b0;
      rows.delete();
      for (int i = 0; i < n; i++) begin
         if (HS) c_hs++;
         if (!VS) c_vs++;
         if (DE) begin
            c_de++;
            if (first_de < 0) begin
               first_de = i;
               chk("first_de_pix_x", int'(PIX_X), 0);
               chk("first_de_pix_y", int'(PIX_Y), 0);
            end
         end
         if (FETCH_REQ) begin
            c_req++;
            if (m_hc != HF0 && !prev_r) c_req_bad++;
            if (!prev_r) rows.push_back(int'(FETCH_ROW));
         end
         if (UNDERRUN) begin
            c_und++;
            if (m_hc != HA0) c_und_bad++;
         end
         prev_r = FETCH_REQ;
         @(negedge clk);
      end
   endtask

   initial begin : stim
      bit ok;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_hs", int'(HS), 0);
      chk("rst_vs", int'(VS), 1);
      chk("rst_de", int'(DE), 0);
      chk("rst_req", int'(FETCH_REQ), 0);
      chk("rst_und", int'(UNDERRUN), 0);
      chk_on = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_hs", int'(HS), 0);
      en = 1'b1;
      @(negedge clk);
      chk("load_hs", int'(HS), 1);
      chk("load_vs", int'(VS), 0);

      ack_mode = 0;
      run_cnt(2 * FRAME);
      chk("hs_cycles", c_hs, 2 * V_TOT * H_SYNC);
      chk("vs_cycles", c_vs, 2 * V_SYNC * H_TOT);
      chk("de_cycles", c_de, 2 * H_ACT * V_ACT);
      chk("first_de_index", first_de, VA0 * H_TOT + HA0);
`ifdef VGA_LINE_FETCH_EN
      chk("req_cycles_tied", c_req, 2 * V_ACT);
      chk("req_bad_col", c_req_bad, 0);
      chk("und_tied", c_und, 0);
      chk("rows_n", rows.size(), 2 * V_ACT);
      for (int i = 0; i < rows.size(); i++) chk("row_order", rows[i], i % V_ACT);
`else
      chk("req_off_cycles", c_req, 0);
      chk("und_off_cycles", c_und, 0);
`endif

      ack_mode = 1; ack_dly = LAST_OK;
      run_cnt(FRAME);
`ifdef VGA_LINE_FETCH_EN
      chk("und_ack_last_ok", c_und, 0);
      chk("req_cycles_last_ok", c_req, V_ACT * (LAST_OK + 1));
`endif

      ack_dly = LAST_OK + 1;
      run_cnt(FRAME);
`ifdef VGA_LINE_FETCH_EN
      chk("und_ack_late", c_und, V_ACT);
      chk("und_late_col", c_und_bad, 0);
      chk("req_cycles_late", c_req, V_ACT * (LAST_OK + 1));
`endif

      ack_mode = 2;
      run_cnt(FRAME);
`ifdef VGA_LINE_FETCH_EN
      chk("und_never", c_und, V_ACT);
      chk("und_never_col", c_und_bad, 0);
`endif

      ack_mode = 3;
      run_cnt(2 * FRAME);

      ack_mode = 2;
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME && !ok; i++) begin
         @(negedge clk);
         if (m_vc == VA0 + 2 && m_hc == 2) ok = 1'b1;
      end
      chk("wait_drop_point", int'(ok), 1);
`ifdef VGA_LINE_FETCH_EN
      chk("req_pending_at_drop", int'(FETCH_REQ), 1);
`endif
      en = 1'b0;
      @(negedge clk);
      chk("drop_hs", int'(HS), 0);
      chk("drop_vs", int'(VS), 1);
      chk("drop_de", int'(DE), 0);
      chk("drop_req", int'(FETCH_REQ), 0);
      chk("drop_und", int'(UNDERRUN), 0);
      repeat (3) @(negedge clk);
      chk("drop_und_hold", int'(UNDERRUN), 0);
      en = 1'b1;
      @(negedge clk);
      chk("reen_hs", int'(HS), 1);
      chk("reen_de", int'(DE), 0);

      ack_mode = 0;
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME && !ok; i++) begin
         @(negedge clk);
         if (m_vc == VA0 + 1 && m_hc == HA0 + 3) ok = 1'b1;
      end
      chk("wait_reset_point", int'(ok), 1);
      chk("pre_reset_de", int'(DE), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hs", int'(HS), 0);
      chk("arst_vs", int'(VS), 1);
      chk("arst_de", int'(DE), 0);
      chk("arst_pix_x", int'(PIX_X), 0);
      chk("arst_req", int'(FETCH_REQ), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
